// File: rtl/digital_transmitter.sv
// rtl/digital_transmitter.sv - framed MSB-first serial word transmitter with bit clock and frame marker
module digital_transmitter #(
    parameter int CLK_DIV     = 4,
    parameter int WORD_BITS   = 12,
    parameter int FRAME_WORDS = 32
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 iEn,
    input  logic [WORD_BITS-1:0] iData,
    input  logic                 iValid,
    output logic                 oReady,
    output logic                 dCLK,
    output logic                 dDAT,
    output logic                 dFM,
    output logic                 oUnderflow,
    output logic                 oFrameDone
);

    localparam int PHASES = 2 * CLK_DIV;
    localparam int PW     = (PHASES > 2) ? $clog2(PHASES) : 1;
    localparam int BW     = (WORD_BITS > 2) ? $clog2(WORD_BITS) : 1;
    localparam int WW     = (FRAME_WORDS > 2) ? $clog2(FRAME_WORDS) : 1;

    typedef enum logic {IDLE, SEND} state_t;

    state_t               state;
    logic [PW-1:0]        phase;
    logic [BW-1:0]        bit_cnt;
    logic [WW-1:0]        word_cnt;
    logic [WORD_BITS-1:0] shift_reg;

    logic          phase_last;
    logic          last_bit;
    logic          last_word;
    logic          load;
    logic          frame_end;
    logic [PW-1:0] next_phase;

    assign phase_last = (phase == PW'(PHASES - 1));
    assign last_bit   = (bit_cnt == '0);
    assign last_word  = (word_cnt == WW'(FRAME_WORDS - 1));
    assign next_phase = phase_last ? '0 : phase + 1'b1;

    // A frame ending with iEn low is not a load cycle: nothing is accepted there.
    assign load = phase_last &&
                  ((state == SEND) ? (last_bit && !(last_word && !iEn)) : iEn);
    assign frame_end = (state == SEND) && phase_last && last_bit && last_word;

    assign oReady = load;
    assign dDAT   = shift_reg[WORD_BITS-1];

    always_ff @(posedge clk) begin
        if (rst) begin
            state      <= IDLE;
            phase      <= '0;
            bit_cnt    <= '0;
            word_cnt   <= '0;
            shift_reg  <= '0;
            dCLK       <= 1'b0;
            dFM        <= 1'b0;
            oUnderflow <= 1'b0;
            oFrameDone <= 1'b0;
        end else begin
            phase      <= next_phase;
            dCLK       <= (next_phase >= PW'(CLK_DIV));
            oUnderflow <= 1'b0;
            oFrameDone <= 1'b0;

            if (load) begin
                state      <= SEND;
                shift_reg  <= iValid ? iData : '0;
                oUnderflow <= !iValid;
                bit_cnt    <= BW'(WORD_BITS - 1);
                if ((state == IDLE) || last_word) begin
                    word_cnt <= '0;
                    dFM      <= 1'b1;
                end else begin
                    word_cnt <= word_cnt + 1'b1;
                    dFM      <= 1'b0;
                end
                if ((state == SEND) && last_word) begin
                    oFrameDone <= 1'b1;
                end
            end else if (frame_end) begin
                state      <= IDLE;
                shift_reg  <= '0;
                bit_cnt    <= '0;
                word_cnt   <= '0;
                dFM        <= 1'b0;
                oFrameDone <= 1'b1;
            end else if ((state == SEND) && phase_last) begin
                bit_cnt   <= bit_cnt - 1'b1;
                shift_reg <= {shift_reg[WORD_BITS-2:0], 1'b0};
                dFM       <= 1'b0;
            end
        end
    end

endmodule

// File: tb/tb_digital_transmitter.sv
// tb/tb_digital_transmitter.sv - self-checking bench for digital_transmitter
module tb_digital_transmitter;

    localparam int CD = 2;
    localparam int WB = 12;
    localparam int FW = 4;
    localparam int P  = 2 * CD;

    logic          clk = 1'b0;
    logic          rst = 1'b1;
    logic          iEn = 1'b0;
    logic [WB-1:0] iData = '0;
    logic          iValid = 1'b0;
    logic          oReady, dCLK, dDAT, dFM, oUnderflow, oFrameDone;

    int n_cmp = 0;
    int n_bad = 0;
    logic chk_on = 1'b0;

    digital_transmitter #(.CLK_DIV(CD), .WORD_BITS(WB), .FRAME_WORDS(FW)) dut (
        .clk(clk), .rst(rst), .iEn(iEn), .iData(iData), .iValid(iValid),
        .oReady(oReady), .dCLK(dCLK), .dDAT(dDAT), .dFM(dFM),
        .oUnderflow(oUnderflow), .oFrameDone(oFrameDone)
    );

    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    // Reference model: tracks the word on the wire by its start time, not by counters.
    int            m_t = 0;
    int            m_start = 0;
    int            m_widx = 0;
    logic          m_busy = 1'b0;
    logic [WB-1:0] m_word = '0;
    logic          m_uf = 1'b0;
    logic          m_fd = 1'b0;

    always @(negedge clk) begin
        int   ph, rel, bidx;
        logic lbe, ld, e_dat, e_fm;
        ph    = m_t % P;
        rel   = m_t - m_start;
        e_dat = 1'b0;
        e_fm  = 1'b0;
        lbe   = 1'b0;
        if (m_busy) begin
            bidx  = rel / P;
            e_dat = m_word[WB-1-bidx];
            e_fm  = (m_widx == 0) && (bidx == 0);
            lbe   = (rel == WB * P - 1);
        end
        ld = (ph == P - 1) && (m_busy ? (lbe && !((m_widx == FW - 1) && !iEn)) : iEn);
        if (chk_on) begin
            chk("model_dclk", dCLK, (ph >= CD));
            chk("model_ddat", dDAT, e_dat);
            chk("model_dfm", dFM, e_fm);
            chk("model_ready", oReady, ld);
            chk("model_underflow", oUnderflow, m_uf);
            chk("model_framedone", oFrameDone, m_fd);
        end
        m_uf = 1'b0;
        m_fd = 1'b0;
        if (rst) begin
            m_t    = 0;
            m_busy = 1'b0;
            m_widx = 0;
        end else begin
            if (ld) begin
                m_word  = iValid ? iData : '0;
                m_uf    = !iValid;
                m_fd    = m_busy && (m_widx == FW - 1);
                m_widx  = (m_busy && (m_widx != FW - 1)) ? m_widx + 1 : 0;
                m_busy  = 1'b1;
                m_start = m_t + 1;
            end else if (lbe) begin
                m_busy = 1'b0;
                m_fd   = 1'b1;
            end
            m_t++;
        end
    end

    typedef struct {
        logic          en;
        logic          valid;
        logic [WB-1:0] data;
        logic [WB-1:0] exp_word;
        logic          exp_uf;
        logic          exp_fm;
        logic          exp_fd;
    } vec_t;

    vec_t tab[8];

    initial begin
        logic [WB-1:0] rx;
        logic          got;
        int            cnt_a, cnt_b, k;

        tab[0] = '{1'b1, 1'b1, 12'hA5C, 12'hA5C, 1'b0, 1'b1, 1'b0};
        tab[1] = '{1'b1, 1'b1, 12'h123, 12'h123, 1'b0, 1'b0, 1'b0};
        tab[2] = '{1'b1, 1'b0, 12'hFFF, 12'h000, 1'b1, 1'b0, 1'b0};
        tab[3] = '{1'b1, 1'b1, 12'hFFF, 12'hFFF, 1'b0, 1'b0, 1'b0};
        tab[4] = '{1'b1, 1'b1, 12'h000, 12'h000, 1'b0, 1'b1, 1'b1};
        tab[5] = '{1'b0, 1'b1, 12'h800, 12'h800, 1'b0, 1'b0, 1'b0};
        tab[6] = '{1'b0, 1'b1, 12'h001, 12'h001, 1'b0, 1'b0, 1'b0};
        tab[7] = '{1'b0, 1'b1, 12'h3C3, 12'h3C3, 1'b0, 1'b0, 1'b0};

        repeat (3) @(posedge clk);
        #1 chk_on = 1'b1;
        @(negedge clk);
        chk("reset_outputs", {dCLK, dDAT, dFM, oReady, oUnderflow, oFrameDone}, 6'b0);
        @(posedge clk);
        #1 rst = 1'b0;

        // Idle after release: dCLK period P, everything else quiet.
        cnt_a = 0;
        cnt_b = 0;
        for (int c = 0; c < 100; c++) begin
            @(negedge clk);
            if (dCLK !== ((c % P) >= CD)) cnt_a++;
            if (oReady || dDAT || dFM) cnt_b++;
        end
        chk("idle_dclk_errors", cnt_a, 0);
        chk("idle_quiet_errors", cnt_b, 0);

        @(posedge clk);
        #1;
        iEn    = 1'b1;
        iValid = tab[0].valid;
        iData  = tab[0].data;
        got    = 1'b0;
        for (int c = 0; c < 20 && !got; c++) begin
            @(negedge clk);
            got = oReady;
        end
        chk("first_ready", got, 1);

        for (int i = 0; i < 8; i++) begin
            @(posedge clk);
            #1;
            iEn = tab[i].en;
            if (i < 7) begin
                iValid = tab[i+1].valid;
                iData  = tab[i+1].data;
            end
            rx = '0;
            for (int c = 0; c < WB * P; c++) begin
                @(negedge clk);
                if (c == 0) begin
                    chk($sformatf("word%0d_underflow", i), oUnderflow, tab[i].exp_uf);
                    chk($sformatf("word%0d_dfm", i), dFM, tab[i].exp_fm);
                    chk($sformatf("word%0d_framedone", i), oFrameDone, tab[i].exp_fd);
                end
                if ((c % P) == CD) rx = {rx[WB-2:0], dDAT};
                if (c == WB * P - 1) chk($sformatf("word%0d_next_ready", i), oReady, (i < 7));
            end
            chk($sformatf("word%0d_serial", i), rx, tab[i].exp_word);
        end
        @(negedge clk);
        chk("frame2_done", oFrameDone, 1);
        cnt_a = 0;
        for (int c = 0; c < 100; c++) begin
            @(negedge clk);
            if (oReady) cnt_a++;
        end
        chk("no_ready_after_stop", cnt_a, 0);

        // Reset in the middle of bit 5 of word 1, then restart.
        @(posedge clk);
        #1;
        iEn    = 1'b1;
        iValid = 1'b1;
        iData  = WB'($urandom);
        got    = 1'b0;
        for (int c = 0; c < 20 && !got; c++) begin
            @(negedge clk);
            got = oReady;
        end
        chk("restart_ready", got, 1);
        repeat (WB * P + 5 * P + 2) @(posedge clk);
        #1 rst = 1'b1;
        @(posedge clk);
        #1 rst = 1'b0;
        @(negedge clk);
        chk("midword_reset_outputs", {dCLK, dDAT, dFM, oReady, oUnderflow, oFrameDone}, 6'b0);
        k = 1;
        got = 1'b0;
        while (!got && k < 60) begin
            @(negedge clk);
            if (dFM) got = 1'b1;
            else k++;
        end
        chk("restart_dfm_cycle", k, 2 * CD);

        // Randomized traffic with occasional resets; the model checks every cycle.
        for (int c = 0; c < 4000; c++) begin
            @(posedge clk);
            #1;
            if ($urandom_range(0, 99) < 3) iEn = ~iEn;
            iValid = ($urandom_range(0, 99) < 85);
            iData  = WB'($urandom);
            rst    = ($urandom_range(0, 999) < 3);
        end
        @(posedge clk);
        #1 rst = 1'b0;
        repeat (10) @(posedge clk);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule

// File: doc/digital_transmitter.md
DIGITAL_TRANSMITTER -- requirements
Module: digital_transmitter

Interface
REQ-001 Parameter CLK_DIV, default 4, clk cycles per dCLK half-period (>=1).
REQ-002 Parameter WORD_BITS, default 12, bits per word.
REQ-003 Parameter FRAME_WORDS, default 32, words per frame (>=2).
REQ-004 clk  in  1  single clock for all logic.
REQ-005 rst  in  1  reset, synchronous and active-high.
REQ-006 iEn  in  1  transmit enable, sampled only at frame boundaries.
REQ-007 iData  in  WORD_BITS  parallel word to send.
REQ-008 iValid  in  1  iData is valid.
REQ-009 oReady  out  1  word-load strobe; a word is accepted when iValid && oReady.
REQ-010 dCLK  out  1  serial bit clock to the receiver.
REQ-011 dDAT  out  1  serial data, MSB first.
REQ-012 dFM  out  1  frame marker.
REQ-013 oUnderflow  out  1  one-cycle pulse when a zero word is substituted.
REQ-014 oFrameDone  out  1  one-cycle pulse at the end of each frame.

Function
REQ-015 States: IDLE, SEND; the bit-phase counter counts 0..2*CLK_DIV-1, the bit counter counts WORD_BITS-1..0, and the word counter counts 0..FRAME_WORDS-1.
REQ-016 Bit period = 2*CLK_DIV clk cycles; dCLK=0 for phase 0..CLK_DIV-1 and dCLK=1 for phase CLK_DIV..2*CLK_DIV-1, free-running in both states.
REQ-017 dDAT and dFM change only at phase 0 (dCLK falling edge); the receiver samples on the dCLK rising edge.
REQ-018 Load cycle = the phase 2*CLK_DIV-1 clk cycle of the last bit of a word in SEND, or any phase-(2*CLK_DIV-1) clk cycle in IDLE with iEn=1.
REQ-019 oReady=1 in load cycles only; otherwise oReady=0.
REQ-020 In a load cycle with iValid=1, iData is latched into the shift register and is sent starting at the next clk cycle (phase 0).
REQ-021 In a load cycle with iValid=0 while a frame is continuing or starting, the shift register is loaded with all zeroes and oUnderflow=1 on the next cycle; no word is consumed.
REQ-022 dDAT = shift register MSB; the register shifts left, filling with 0, at each phase-0 boundary after the first bit of a word.
REQ-023 dFM=1 for the full bit period of bit 0 (MSB) of word 0 of each frame; otherwise dFM=0.
REQ-024 IDLE->SEND at a load cycle with iEn=1, and the word counter is set to 0.
REQ-025 At the load cycle ending word FRAME_WORDS-1: oFrameDone=1 on the next cycle; if iEn=1, a new frame starts seamlessly with word 0 and dFM; if iEn=0, the block goes to IDLE, oReady=0, and no word is accepted.
REQ-026 iEn deasserted mid-frame has no effect until the frame boundary; frames are never truncated.
REQ-027 In IDLE, dDAT=0, dFM=0, and dCLK keeps toggling.
REQ-028 iData and iValid are ignored outside load cycles; iData is held internally for the whole word.

Reset
REQ-029 With rst=1 at a clk edge: state=IDLE, all counters=0, shift register=0, dCLK=0, dDAT=0, dFM=0, oReady=0, oUnderflow=0, oFrameDone=0.
REQ-030 Reset mid-word or mid-frame aborts immediately; the partial word is discarded, and after release the phase restarts at 0 (dCLK low for CLK_DIV cycles).
REQ-031 The first load cycle after reset release occurs at clk cycle 2*CLK_DIV-1 after release, if iEn=1.

Verification (CLK_DIV=2, WORD_BITS=12, FRAME_WORDS=4)
REQ-032 Reset release, iEn=0 for 100 cycles -> dCLK toggles with period 4, oReady=0, dDAT=0, dFM=0.
REQ-033 iEn=1, iValid=1, words 0xA5C,0x123,0xFFF,0x000 -> serial MSB-first 101001011100 000100100011 ..., dFM high only during the first 4 cycles of 0xA5C, oReady pulses every 48 cycles, oFrameDone after cycle 192 of the frame.
REQ-034 iValid=0 at the load cycle for word 2 -> word 2 is sent as 12 zeroes, oUnderflow pulses once, and the next valid word is sent as word 3.
REQ-035 iEn dropped during word 1 -> words 1..3 complete, oFrameDone pulses, IDLE follows, and no further oReady occurs.
REQ-036 iEn held high for 2 frames -> second dFM pulse starts exactly 192 cycles after the first, with no gap bits.
REQ-037 rst asserted mid-bit 5 of word 1 -> all outputs are 0 next cycle, and the restart produces dFM on the first word after the first load cycle.
